brr_seq: RTL and testbench



---
 rtl/brr_pkg.sv | 27 ++
 rtl/brr_step.sv | 46 ++++
 rtl/brr_seq.sv | 162 ++++++++++++++++
 tb/tb_brr_seq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/brr_pkg.sv
// -----------------------------------------------------------------------------
// brr_pkg
// Shared definitions for the sequential rotate/shift-right unit (brr_seq).
//   - Opcode encodings accepted on i_op.
//   - FSM state encoding used by the sequencer.
//   - A small helper that returns the per-request step count.
// -----------------------------------------------------------------------------
package brr_pkg;

  // Operation encodings (2-bit i_op).
  localparam logic [1:0] OP_ROR  = 2'b00;  // rotate right, bit0 wraps to MSB
  localparam logic [1:0] OP_SRL  = 2'b01;  // logical shift right, 0 enters MSB
  localparam logic [1:0] OP_SRA  = 2'b10;  // arithmetic shift right, MSB replicated
  localparam logic [1:0] OP_PASS = 2'b11;  // pass-through, operand unchanged

  // Sequencer states.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Pass-through requests never step, whatever amount came with them.
  function automatic logic force_zero_cnt(input logic [1:0] op);
    return (op == OP_PASS);
  endfunction

endpackage : brr_pkg

// File: rtl/brr_step.sv
// -----------------------------------------------------------------------------
// brr_step
// Combinational single-position right step of the rotate/shift unit.
//   ROR  : data rotates right by one, bit0 re-enters at the MSB.
//   SRL  : data shifts right by one, a zero enters at the MSB.
//   SRA  : data shifts right by one, the MSB is replicated.
//   PASS : data is returned unchanged.
//
// Parameters
//   WIDTH   data width in bits
// Ports
//   data_i  [WIDTH-1:0]  value before the step
//   op_i    [1:0]        operation select (brr_pkg OP_*)
//   data_o  [WIDTH-1:0]  value after one step
// -----------------------------------------------------------------------------
module brr_step
  import brr_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [1:0]       op_i,
  output logic [WIDTH-1:0] data_o
);

  // Bit that enters the MSB position for each operation.
  logic msb_in;

  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    msb_in = 1'b0;
    data_o = data_i;
    unique case (op_i)
      OP_ROR:  msb_in = data_i[0];
      OP_SRL:  msb_in = 1'b0;
      OP_SRA:  msb_in = data_i[WIDTH-1];
      OP_PASS: msb_in = 1'b0;
      default: msb_in = 1'b0;
    endcase
    if (op_i != OP_PASS) begin
      data_o = {msb_in, data_i[WIDTH-1:1]};
    end
  end

endmodule : brr_step

// File: rtl/brr_seq.sv
// -----------------------------------------------------------------------------
// brr_seq
// Sequential barrel rotate/shift-right unit. One request is accepted through a
// start/busy/done handshake; the operand is stepped right one position per
// clock (ROR, SRL or SRA) until the amount is exhausted, then the result is
// registered and held until the next accepted request completes.
//
// Build option
//   BRR_FAST_EN  when defined, the SHIFT state performs the whole log2(WIDTH)-
//                stage barrel operation in a single clock, so o_done always
//                follows the first edge after acceptance. Results are
//                identical to the iterative build; only o_done timing differs.
//
// Parameters
//   WIDTH     operand/result width (default 32)
//   AW        shift-amount width, $clog2(WIDTH) (derived, not overridden)
// Ports
//   i_clk     clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   i_start   request strobe, sampled only while o_busy = 0
//   i_op      [1:0] 00 ROR, 01 SRL, 10 SRA, 11 pass-through
//   i_b       [WIDTH-1:0] operand
//   sel_a     [AW-1:0] shift amount (modulo WIDTH by width)
//   o_busy    operation in progress
//   o_done    one-cycle pulse, o_result is valid
//   o_result  [WIDTH-1:0] result, held until the next completion
// -----------------------------------------------------------------------------
module brr_seq
  import brr_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_b,
  input  logic [AW-1:0]    sel_a,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);

  state_e           state_q;
  logic [WIDTH-1:0] sr_q;       // working shift register
  logic [AW-1:0]    cnt_q;      // remaining step count
  logic [1:0]       op_q;       // operation captured at acceptance
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;

  // Value the shift register takes on the next SHIFT edge.
  logic [WIDTH-1:0] step_d;

`ifdef BRR_FAST_EN
  // Full barrel: stage k applies 2^k single steps when bit k of the count is
  // set. Each stage is a chain of brr_step instances so the per-bit behaviour
  // is shared with the iterative build and results stay bit-identical.
  logic [WIDTH-1:0] stage_w [AW+1];

  assign stage_w[0] = sr_q;

  for (genvar k = 0; k < AW; k++) begin : g_stage
    localparam int REPS = 1 << k;
    logic [WIDTH-1:0] chain_w [REPS+1];

    assign chain_w[0] = stage_w[k];

    for (genvar j = 0; j < REPS; j++) begin : g_rep
      brr_step #(
        .WIDTH (WIDTH)
      ) u_step (
        .data_i (chain_w[j]),
        .op_i   (op_q),
        .data_o (chain_w[j+1])
      );
    end

    assign stage_w[k+1] = cnt_q[k] ? chain_w[REPS] : stage_w[k];
  end

  assign step_d = stage_w[AW];
`else
  brr_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .data_i (sr_q),
    .op_i   (op_q),
    .data_o (step_d)
  );
`endif

  // Sequencer with registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      sr_q     <= '0;
      cnt_q    <= '0;
      op_q     <= OP_ROR;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values; blocking here would create order-dependent
      // simulation and a mismatch with synthesized hardware.
      done_q <= 1'b0;  // o_done is a single-cycle pulse unless re-asserted below

      unique case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            sr_q    <= i_b;
            cnt_q   <= force_zero_cnt(i_op) ? '0 : sel_a;
            op_q    <= i_op;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
`ifdef BRR_FAST_EN
          // Whole amount applied in one edge; cnt = 0 leaves the value as is.
          sr_q     <= step_d;
          cnt_q    <= '0;
          result_q <= step_d;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
`else
          if (cnt_q == '0) begin
            // Zero amount or pass-through: finish on the first SHIFT edge
            // with the unstepped operand.
            result_q <= sr_q;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end else begin
            sr_q  <= step_d;
            cnt_q <= cnt_q - AW'(1);
            // Last step: publish the stepped value on this same edge so the
            // request completes after exactly n edges.
            if (cnt_q == AW'(1)) begin
              result_q <= step_d;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= ST_IDLE;
            end
          end
`endif
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_result = result_q;

endmodule : brr_seq

// File: tb/tb_brr_seq.sv
// -----------------------------------------------------------------------------
// tb_brr_seq
// Self-checking bench for brr_seq. Directed requests push their hand-computed
// result and expected latency into a scoreboard; an independent monitor pops
// and compares each time o_done is seen.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_brr_seq;

  localparam int WIDTH = 32;
  localparam int AW    = 5;

  logic             clk;
  logic             rst_n;
  logic             i_start;
  logic [1:0]       i_op;
  logic [WIDTH-1:0] i_b;
  logic [AW-1:0]    sel_a;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_result;

  brr_seq #(.WIDTH(WIDTH)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (i_start),
    .i_op     (i_op),
    .i_b      (i_b),
    .sel_a    (sel_a),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_result (o_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef BRR_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  typedef struct {
    logic [WIDTH-1:0] res;
    int               acc;
    int               lat;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every o_done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (o_done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", o_result, e.res);
        check("latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  function automatic int exp_lat(input logic [1:0] op, input int amt);
    if (FAST || op == 2'b11 || amt == 0) return 1;
    return amt;
  endfunction

  // Drive a request starting now; accepted at the next rising edge.
  task automatic issue_now(input logic [1:0] op, input logic [31:0] b, input int amt,
                           input logic [31:0] res, input bit push);
    exp_t e;
    i_start = 1'b1;
    i_op    = op;
    i_b     = b;
    sel_a   = AW'(amt);
    @(posedge clk);
    #1;
    i_start = 1'b0;
    // Inputs changing after acceptance must have no effect.
    i_op    = 2'($urandom);
    i_b     = $urandom;
    sel_a   = AW'($urandom);
    if (push) begin
      e.res = res;
      e.acc = cyc;
      e.lat = exp_lat(op, amt);
      sb.push_back(e);
    end
    check("accept_busy", {31'd0, o_busy}, 32'd1);
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] b, input int amt,
                       input logic [31:0] res);
    @(negedge clk);
    issue_now(op, b, amt, res, 1'b1);
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && sb.size() != 0; i++) @(negedge clk);
    check("drain_outstanding", 32'(sb.size()), 32'd0);
    sb.delete();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    i_start = 1'b0;
    i_op    = 2'b00;
    i_b     = '0;
    sel_a   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // Reset state with no stimulus.
    check("rst_busy",   {31'd0, o_busy}, 32'd0);
    check("rst_done",   {31'd0, o_done}, 32'd0);
    check("rst_result", o_result,        32'h0000_0000);

    // Basic operations.
    issue(2'b00, 32'h8000_0001, 1,  32'hC000_0000); drain(10);
    issue(2'b10, 32'h8000_0000, 4,  32'hF800_0000); drain(10);
    issue(2'b01, 32'h8000_0000, 4,  32'h0800_0000); drain(10);
    issue(2'b00, 32'h1234_5678, 0,  32'h1234_5678); drain(10);
    issue(2'b11, 32'h1234_5678, 5,  32'h1234_5678); drain(10);
    issue(2'b00, 32'h1234_5678, 8,  32'h7812_3456); drain(20);
    issue(2'b10, 32'h4000_0000, 3,  32'h0800_0000); drain(20);
    issue(2'b10, 32'hFFFF_0000, 31, 32'hFFFF_FFFF); drain(40);

    // Result holds after completion.
    repeat (3) @(negedge clk);
    check("result_hold", o_result, 32'hFFFF_FFFF);

    // Long rotate; ignored start while busy; back-to-back start in done cycle.
    issue(2'b00, 32'h0000_0001, 31, 32'h0000_0002);
`ifndef BRR_FAST_EN
    repeat (4) @(posedge clk);
    @(negedge clk);
    i_start = 1'b1;
    i_op    = 2'b01;
    i_b     = 32'hDEAD_BEEF;
    sel_a   = AW'(3);
    @(posedge clk);
    #1;
    i_start = 1'b0;
    check("ignored_busy", {31'd0, o_busy}, 32'd1);
`endif
    for (int i = 0; i < 60 && !o_done; i++) @(negedge clk);
    check("done_seen", {31'd0, o_done}, 32'd1);
    issue_now(2'b01, 32'h0000_00F0, 4, 32'h0000_000F, 1'b1);
    drain(20);

    // Reset mid-operation: abort with no o_done for the request.
    @(negedge clk);
    issue_now(2'b01, 32'hFFFF_FFFF, 20, 32'h0000_0FFF, FAST);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy",   {31'd0, o_busy}, 32'd0);
    check("abort_done",   {31'd0, o_done}, 32'd0);
    check("abort_result", o_result,        32'h0000_0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_busy",   {31'd0, o_busy}, 32'd0);
    check("post_rst_result", o_result,        32'h0000_0000);
    drain(2);

    // First request after release processes normally.
    issue(2'b01, 32'hFFFF_FFFF, 8, 32'h00FF_FFFF); drain(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_brr_seq
